hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Detects load-use hazards,

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, CUS multi-cycle EX stalls, memory wait stalls, branch squash.
// Control outputs are combinational from state+inputs; mem_busy holds all four stages.
module hazard_ctrl #(
  parameter int CUS_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use1,
  input  logic             IF_ID_use2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_is_load,
  input  logic             ID_EX_is_cus,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             HLT_IF,
  output logic             HLT_ID,
  output logic             HLT_EX,
  output logic             HLT_MEM,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             CUS_BUSY,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {RUN, CUS_WAIT, MEM_WAIT} state_t;

  localparam int CW = (CUS_LAT > 2) ? $clog2(CUS_LAT) : 1;
  // The entry cycle is the first stall cycle, so CUS_WAIT lasts CUS_LAT-2 cycles.
  localparam logic [CW-1:0] CUS_LOAD = CW'((CUS_LAT > 2) ? CUS_LAT - 3 : 0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cus_cnt_q, cus_cnt_d;
  logic             cus_done_q, cus_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hlt_if, hlt_id, hlt_ex, hlt_mem, flush_ifid, flush_idex, cus_busy;
  logic lu_haz, run_eval;

  assign lu_haz = ID_EX_is_load && (ID_EX_rd != 5'd0) &&
                  ((IF_ID_use1 && (IF_ID_rs1 == ID_EX_rd)) ||
                   (IF_ID_use2 && (IF_ID_rs2 == ID_EX_rd)));

  // A MEM_WAIT cycle with memory ready is evaluated exactly like RUN.
  assign run_eval = (state_q == RUN) || ((state_q == MEM_WAIT) && !mem_busy);

  always_comb begin
    state_d    = state_q;
    cus_cnt_d  = cus_cnt_q;
    cus_done_d = 1'b0;
    hlt_if     = 1'b0;
    hlt_id     = 1'b0;
    hlt_ex     = 1'b0;
    hlt_mem    = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    cus_busy   = 1'b0;
    if (run_eval) begin
      state_d = RUN;
      if (mem_busy) begin
        {hlt_if, hlt_id, hlt_ex, hlt_mem} = 4'b1111;
        cus_done_d = cus_done_q;
        state_d    = MEM_WAIT;
      end else if (ID_EX_is_cus && (CUS_LAT > 1) && !cus_done_q) begin
        {hlt_if, hlt_id, hlt_ex} = 3'b111;
        cus_busy  = 1'b1;
        cus_cnt_d = CUS_LOAD;
        if (CUS_LAT > 2) state_d = CUS_WAIT;
        else cus_done_d = 1'b1;
      end else if (branch_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (lu_haz) begin
        hlt_if     = 1'b1;
        hlt_id     = 1'b1;
        flush_idex = 1'b1;
      end
    end else if (state_q == CUS_WAIT) begin
      {hlt_if, hlt_id, hlt_ex} = 3'b111;
      hlt_mem  = mem_busy;
      cus_busy = 1'b1;
      if (cus_cnt_q != '0) begin
        cus_cnt_d = cus_cnt_q - 1'b1;
      end else begin
        // The finished CUS op is still in EX on the release cycle; don't re-trigger on it.
        cus_done_d = 1'b1;
        state_d    = mem_busy ? MEM_WAIT : RUN;
      end
    end else begin
      {hlt_if, hlt_id, hlt_ex, hlt_mem} = 4'b1111;
      cus_done_d = cus_done_q;
    end
  end

  assign HLT_IF     = hlt_if     && !RES;
  assign HLT_ID     = hlt_id     && !RES;
  assign HLT_EX     = hlt_ex     && !RES;
  assign HLT_MEM    = hlt_mem    && !RES;
  assign FLUSH_IFID = flush_ifid && !RES;
  assign FLUSH_IDEX = flush_idex && !RES;
  assign CUS_BUSY   = cus_busy   && !RES;
  assign STALL_CNT  = stall_cnt_q;

  assign stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, HLT_IF};

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= RUN;
      cus_cnt_q   <= '0;
      cus_done_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cus_cnt_q   <= cus_cnt_d;
      cus_done_q  <= cus_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CUS_LAT=3): inputs driven on the falling edge, outputs checked 2 ns later.
module tb_hazard_ctrl;
  logic        CLK = 1'b0;
  logic        RES;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic        IF_ID_use1, IF_ID_use2, ID_EX_is_load, ID_EX_is_cus, branch_taken, mem_busy;
  logic        HLT_IF, HLT_ID, HLT_EX, HLT_MEM, FLUSH_IFID, FLUSH_IDEX, CUS_BUSY;
  logic [31:0] STALL_CNT;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CUS_LAT(3), .CNT_W(32)) dut (
    .CLK(CLK), .RES(RES),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use1(IF_ID_use1), .IF_ID_use2(IF_ID_use2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_is_load(ID_EX_is_load), .ID_EX_is_cus(ID_EX_is_cus),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .HLT_IF(HLT_IF), .HLT_ID(HLT_ID), .HLT_EX(HLT_EX), .HLT_MEM(HLT_MEM),
    .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX), .CUS_BUSY(CUS_BUSY),
    .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  // Next cycle's inputs: {load, cus, branch, mem_busy}, rd, rs1, rs2, use1, use2.
  task automatic cyc(input logic rst, input logic [3:0] ctl, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
    @(negedge CLK);
    RES = rst;
    {ID_EX_is_load, ID_EX_is_cus, branch_taken, mem_busy} = ctl;
    ID_EX_rd = rd; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; IF_ID_use1 = u1; IF_ID_use2 = u2;
    #2;
  endtask

  // Expected {HLT_IF, HLT_ID, HLT_EX, HLT_MEM, FLUSH_IFID, FLUSH_IDEX, CUS_BUSY}.
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {HLT_IF, HLT_ID, HLT_EX, HLT_MEM, FLUSH_IFID, FLUSH_IDEX, CUS_BUSY};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (STALL_CNT === exp) else begin
      errors++;
      $error("FAIL %s: observed STALL_CNT=%0d expected %0d", tag, STALL_CNT, exp);
    end
  endtask

  initial begin
    RES = 1'b1;
    {ID_EX_is_load, ID_EX_is_cus, branch_taken, mem_busy} = 4'b0;
    ID_EX_rd = '0; IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_use1 = 1'b0; IF_ID_use2 = 1'b0;

    // Reset held with mem_busy and a load-use pattern: outputs forced low.
    cyc(1'b1, 4'b1001, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    chk_ctl("reset_outputs", 7'b0000000);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("idle_after_reset", 7'b0000000);
    chk_cnt("cnt_after_reset", 32'd0);

    // Load-use on rs1: one bubble.
    cyc(1'b0, 4'b1000, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    chk_ctl("lu_rs1", 7'b1100010);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("lu_rs1_released", 7'b0000000);
    chk_cnt("cnt_after_lu", 32'd1);

    // No hazard when rd=0 or the register is not read; rs2 path does stall.
    cyc(1'b0, 4'b1000, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk_ctl("lu_rd0", 7'b0000000);
    cyc(1'b0, 4'b1000, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
    chk_ctl("lu_nouse", 7'b0000000);
    cyc(1'b0, 4'b1000, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1);
    chk_ctl("lu_rs2", 7'b1100010);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_cnt("cnt_after_rs2", 32'd2);

    // Taken branch squashes; beats a simultaneous load-use hazard.
    cyc(1'b0, 4'b0010, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("branch", 7'b0000110);
    cyc(1'b0, 4'b1010, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    chk_ctl("branch_over_lu", 7'b0000110);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("branch_single", 7'b0000000);
    chk_cnt("cnt_after_branch", 32'd2);

    // CUS op, CUS_LAT=3: two stall cycles, then the pipeline moves on.
    cyc(1'b0, 4'b0100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cus_c1", 7'b1110001);
    cyc(1'b0, 4'b0100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cus_c2", 7'b1110001);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cus_done", 7'b0000000);
    chk_cnt("cnt_after_cus", 32'd4);

    // mem_busy for 4 cycles over a load-use hazard, then one bubble.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'b1001, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      chk_ctl($sformatf("mem_wait_%0d", i), 7'b1111000);
    end
    cyc(1'b0, 4'b1000, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    chk_ctl("mem_exit_bubble", 7'b1100010);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("mem_exit_idle", 7'b0000000);
    chk_cnt("cnt_after_mem", 32'd9);

    // mem_busy on the last CUS cycle adds HLT_MEM and goes to MEM_WAIT.
    cyc(1'b0, 4'b0100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusmem_c1", 7'b1110001);
    cyc(1'b0, 4'b0101, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusmem_c2", 7'b1111001);
    cyc(1'b0, 4'b0001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusmem_wait", 7'b1111000);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusmem_exit", 7'b0000000);
    chk_cnt("cnt_after_cusmem", 32'd12);

    // Reset inside CUS_WAIT aborts at once.
    cyc(1'b0, 4'b0100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusres_c1", 7'b1110001);
    cyc(1'b1, 4'b0100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusres_res", 7'b0000000);
    chk_cnt("cnt_before_res_edge", 32'd13);
    cyc(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ctl("cusres_after", 7'b0000000);
    chk_cnt("cnt_after_res", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
